// File: rtl/alu_kontrol_cozucu.sv
// Purpose : decode RV32I OP/OP-IMM into ALU control code + operands, held in a valid/ready register.
// Latency : 1 cycle from accept to out_valid_o.
// Backpr. : bundle held stable while out_ready_i is low; build with ALU_KONTROL_SKID_EN for a
//           2-entry skid (registered in_ready_o); otherwise in_ready_o = !out_valid_o || out_ready_i.
module alu_kontrol_cozucu #(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_CNTR   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [4:0]            rs1_addr_o,
    output logic [4:0]            rs2_addr_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ALU_CNTR-1:0]   alu_cntr_o,
    output logic [DATA_WIDTH-1:0] op_a_o,
    output logic [DATA_WIDTH-1:0] op_b_o,
    output logic [4:0]            rd_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  illegal_o
);

    // ALU control encoding understood by the ALU.
    localparam logic [ALU_CNTR-1:0] ALU_ADD  = ALU_CNTR'(0);
    localparam logic [ALU_CNTR-1:0] ALU_SUB  = ALU_CNTR'(1);
    localparam logic [ALU_CNTR-1:0] ALU_SLL  = ALU_CNTR'(2);
    localparam logic [ALU_CNTR-1:0] ALU_SLT  = ALU_CNTR'(3);
    localparam logic [ALU_CNTR-1:0] ALU_SLTU = ALU_CNTR'(4);
    localparam logic [ALU_CNTR-1:0] ALU_XOR  = ALU_CNTR'(5);
    localparam logic [ALU_CNTR-1:0] ALU_SRL  = ALU_CNTR'(6);
    localparam logic [ALU_CNTR-1:0] ALU_SRA  = ALU_CNTR'(7);
    localparam logic [ALU_CNTR-1:0] ALU_OR   = ALU_CNTR'(8);
    localparam logic [ALU_CNTR-1:0] ALU_AND  = ALU_CNTR'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic                  illegal;
        logic [ALU_CNTR-1:0]   alu_cntr;
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        logic [4:0]            rd;
        logic                  we;
        logic [DATA_WIDTH-1:0] pc;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       accept;
    bundle_t    dec;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    // Combinational decode of the incoming instruction into a candidate bundle.
    always_comb begin
        logic                legal;
        logic [ALU_CNTR-1:0] code;
        logic [DATA_WIDTH-1:0] opb;
        legal = 1'b0;
        code  = ALU_ADD;
        opb   = '0;
        if (opcode == OPC_OP) begin
            opb = rs2_data_i;
            if (funct7 == F7_ZERO) begin
                legal = 1'b1;
                unique case (funct3)
                    3'b000:  code = ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    code  = ALU_SUB;
                end else if (funct3 == 3'b101) begin
                    legal = 1'b1;
                    code  = ALU_SRA;
                end
            end
        end else if (opcode == OPC_OP_IMM) begin
            opb = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
            legal = 1'b1;
            unique case (funct3)
                3'b000:  code = ALU_ADD;
                3'b010:  code = ALU_SLT;
                3'b011:  code = ALU_SLTU;
                3'b100:  code = ALU_XOR;
                3'b110:  code = ALU_OR;
                3'b111:  code = ALU_AND;
                3'b001: begin
                    // Shift-immediates only use the 5-bit shamt; the upper field is funct7.
                    opb   = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
                    code  = ALU_SLL;
                    legal = (funct7 == F7_ZERO);
                end
                default: begin
                    opb = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
                    if (funct7 == F7_ZERO) begin
                        code = ALU_SRL;
                    end else if (funct7 == F7_ALT) begin
                        code = ALU_SRA;
                    end else begin
                        legal = 1'b0;
                    end
                end
            endcase
        end

        dec.illegal  = !legal;
        dec.alu_cntr = legal ? code : ALU_ADD;
        dec.op_a     = legal ? rs1_data_i : '0;
        dec.op_b     = legal ? opb : '0;
        dec.rd       = instr_i[11:7];
        dec.we       = legal && (instr_i[11:7] != 5'd0);
        dec.pc       = pc_i;
    end

    bundle_t main_q, main_d;
    logic    main_vld_q, main_vld_d;

    assign accept = in_valid_i && in_ready_o && !flush_i;

`ifdef ALU_KONTROL_SKID_EN
    bundle_t skid_q, skid_d;
    logic    skid_vld_q, skid_vld_d;
    logic    in_rdy_q, in_rdy_d;

    // in_ready_o tracks skid occupancy one edge late, so an accept can only
    // happen while the skid entry is empty.
    assign in_ready_o = in_rdy_q;

    // Next-state for main + skid entries; flush wins over everything.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_ready_i) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            // Main entry stalled: park the in-flight transfer behind it.
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
        in_rdy_d = !skid_vld_d;
    end

    // Skid entry and registered ready, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end
`else
    // Single register: ready whenever the held bundle is absent or leaving.
    assign in_ready_o = !main_vld_q || out_ready_i;

    // Next-state for the single holding register; flush wins over accept and drain.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = dec;
            main_vld_d = 1'b1;
        end else if (out_ready_i) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    // Main output entry, cleared to the reset bundle (ADD code, zero fields).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    assign out_valid_o = main_vld_q;
    assign alu_cntr_o  = main_q.alu_cntr;
    assign op_a_o      = main_q.op_a;
    assign op_b_o      = main_q.op_b;
    assign rd_o        = main_q.rd;
    assign we_o        = main_q.we;
    assign pc_o        = main_q.pc;
    assign illegal_o   = main_q.illegal;

endmodule
